ps2_rx: RTL and testbench
=========================

PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive equal synchronised ps2_clk samples required before the filtered clock changes level.
REQ-002 Parameter TIMEOUT_CYCLES, default 16384: clk cycles without a filtered ps2_clk falling edge before a partial frame is abandoned (PS2_TIMEOUT_EN only).
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ps2_clk  in  1  raw PS/2 clock pin, asynchronous to clk.
REQ-006 ps2_data  in  1  raw PS/2 data pin, asynchronous to clk.
REQ-007 ps2_key  out  11  [10] event strobe, [9] pressed (1=make, 0=break), [8] extended (E0 prefix), [7:0] scan code.
REQ-008 frame_err  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-FF synchroniser; synchronised ps2_clk SHALL then pass through the FILTER_LEN glitch filter.
REQ-010 A falling edge SHALL be the filtered clock going 1->0; ps2_data SHALL be sampled (synchronised value) in that same cycle.
REQ-011 Frame FSM states: IDLE, DATA, PARITY, STOP; state changes occur only on falling edges (or timeout/reset).
REQ-012 IDLE: on an edge with data=0 go to DATA with bit count 0; data=1 SHALL be ignored and the FSM stays in IDLE.
REQ-013 DATA: shift the sampled bit in LSB-first; after the 8th bit go to PARITY.
REQ-014 PARITY: capture the bit; the 8 data bits plus the parity bit SHALL have odd parity; go to STOP.
REQ-015 STOP: frame valid iff stop bit = 1 and parity is good; always return to IDLE.
REQ-016 An invalid frame SHALL pulse frame_err for one cycle, discard the byte, and clear the break and extended prefix flags.
REQ-017 Valid byte 0xF0 SHALL set the break flag; 0xE0 SHALL set the extended flag; neither produces an event.
REQ-018 Valid byte 0xE1 SHALL start a discard counter; the next 7 valid bytes (Pause sequence) SHALL be dropped without events or flag changes.
REQ-019 Valid bytes 0x00, 0xAA, 0xFA, 0xFC, 0xFD, 0xFE, 0xFF SHALL be dropped silently without events; prefix flags SHALL be cleared.
REQ-020 Any other valid byte SHALL set ps2_key[9:0] = {~break, extended, byte} and assert ps2_key[10]; both prefix flags SHALL then be cleared.
REQ-021 ps2_key[10] SHALL be high for exactly one clk cycle, in the cycle after the stop-bit edge, with ps2_key[9:0] valid in that cycle.
REQ-022 ps2_key[9:0] SHALL hold their last value until the next event.
REQ-023 Two events are never closer than one PS/2 frame; no queuing is required.

Reset
REQ-024 reset SHALL force state IDLE; clear bit count, shift register, prefix flags and discard counter; set ps2_key=11'h000 and frame_err=0; and preset the synchroniser and filter to 1 (bus idle).
REQ-025 reset asserted mid-frame SHALL discard the partial frame without a frame_err pulse; reception SHALL restart at the next start bit.

Configuration
REQ-026 With PS2_TIMEOUT_EN defined, a counter SHALL run while the state is not IDLE and clear on each falling edge; on reaching TIMEOUT_CYCLES the FSM returns to IDLE, the partial byte is discarded, and frame_err pulses once.
REQ-027 Without PS2_TIMEOUT_EN, no timeout counter SHALL exist; a truncated frame is resolved only by subsequent edges or reset.

Verification
REQ-028 Frame 0x1C (parity 0, stop 1) -> single ps2_key pulse, value 11'h61C; frame_err stays 0.
REQ-029 Frames F0, 1C -> one pulse only, value 11'h41C.
REQ-030 Frames E0, 75, then E0, F0, 75 -> pulses 11'h775, then 11'h575.
REQ-031 Frame 0x1C with parity bit flipped -> frame_err pulse, no strobe; following good 0x29 -> 11'h629.
REQ-032 Sequence E1 14 77 E1 F0 14 F0 77, then 0x1C -> no strobe during the sequence, then 11'h61C.
REQ-033 PS2_TIMEOUT_EN: start bit + 4 data bits, then clock idle for TIMEOUT_CYCLES+10 -> one frame_err pulse; next frame 0x29 -> 11'h629. Single-cycle ps2_clk glitches in IDLE -> no state change.

Source files
------------

// File: rtl/ps2_rx_if.sv
// PS/2 receiver pin and key-event bundle.
// master drives the PS/2 pins, slave is the receiver.
interface ps2_rx_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  ps2_key,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output ps2_key,
        output frame_err
    );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchroniser, clock glitch filter, frame FSM, scan decode.
// Optional frame timeout enabled by defining PS2_TIMEOUT_EN.
module ps2_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic      clk,
    input  logic      reset,
    ps2_rx_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;
    logic          sdata;
    logic          tmo_hit;

    state_t        state_q, state_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic [2:0]    disc_q, disc_d;
    logic [10:0]   key_q, key_d;
    logic          err_q, err_d;
    logic          frame_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
        end else begin
            clk_s1_q <= bus.ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= bus.ps2_data;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
        end
    end

    // Level only changes after FILTER_LEN consecutive disagreeing samples
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FMAX) filt_d = clk_s2_q;
            else                fcnt_d = fcnt_q + FW'(1);
        end
    end

    assign fall  = filt_q & ~filt_d;
    assign sdata = dat_s2_q;

`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d   = '0;
        tmo_hit = 1'b0;
        if (state_q != IDLE && !fall) begin
            if (tmo_q == TMAX) tmo_hit = 1'b1;
            else               tmo_d   = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            disc_q  <= '0;
            key_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            brk_q   <= brk_d;
            ext_q   <= ext_d;
            disc_q  <= disc_d;
            key_q   <= key_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tmo_hit) begin
            state_d = IDLE;
        end else if (fall) begin
            unique case (state_q)
                IDLE:   if (!sdata) state_d = DATA;
                DATA:   if (bcnt_q == 3'd7) state_d = PARITY;
                PARITY: state_d = STOP;
                STOP:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign frame_ok = sdata & (^{par_q, shift_q});

    always_comb begin
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        brk_d   = brk_q;
        ext_d   = ext_q;
        disc_d  = disc_q;
        key_d   = {1'b0, key_q[9:0]};
        err_d   = 1'b0;
        if (tmo_hit) begin
            err_d = 1'b1;
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (fall) begin
            unique case (state_q)
                IDLE:   bcnt_d = '0;
                DATA: begin
                    shift_d = {sdata, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                end
                PARITY: par_d = sdata;
                STOP: begin
                    if (!frame_ok) begin
                        err_d = 1'b1;
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end else if (disc_q != 3'd0) begin
                        disc_d = disc_q - 3'd1;
                    end else if (shift_q == 8'hE1) begin
                        disc_d = 3'd7;
                    end else if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (shift_q inside {8'h00, 8'hAA, 8'hFA, 8'hFC,
                                                 8'hFD, 8'hFE, 8'hFF}) begin
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end else begin
                        key_d = {1'b1, ~brk_q, ext_q, shift_q};
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ps2_key   = key_q;
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_ps2_rx.sv
// Randomised self-checking bench for ps2_rx against a scan-code model.
// Timeout scenario runs only when PS2_TIMEOUT_EN is defined.
module tb_ps2_rx;
    localparam int H   = 10;
    localparam int TMO = 16384;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ps2_rx_if bus();

    ps2_rx #(
        .FILTER_LEN(4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int err_seen = 0;
    int exp_err  = 0;
    int dbl      = 0;
    logic prev_stb = 1'b0;

    logic [10:0] got_q[$];
    logic [10:0] exp_q[$];

    bit          m_brk;
    bit          m_ext;
    int          m_disc;
    logic [9:0]  m_last;

    logic [7:0] ign [7] = '{8'h00, 8'hAA, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ps2_key[10]) got_q.push_back(bus.ps2_key);
            if (bus.ps2_key[10] && prev_stb) dbl++;
            if (bus.frame_err) err_seen++;
            prev_stb = bus.ps2_key[10];
        end else begin
            prev_stb = 1'b0;
        end
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(logic [7:0] b, bit pflip, bit stop, int nbits);
        logic [10:0] f;
        f = {stop, (~^b) ^ pflip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = f[i];
            cyc(H);
            bus.ps2_clk = 1'b0;
            cyc(H);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
        cyc(H);
    endtask

    task automatic model_reset();
        m_brk  = 0;
        m_ext  = 0;
        m_disc = 0;
        m_last = '0;
    endtask

    task automatic model(logic [7:0] b, bit good);
        logic [10:0] k;
        if (!good) begin
            exp_err++;
            m_brk = 0;
            m_ext = 0;
        end else if (m_disc > 0) begin
            m_disc--;
        end else if (b == 8'hE1) begin
            m_disc = 7;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b inside {8'h00, 8'hAA, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF}) begin
            m_brk = 0;
            m_ext = 0;
        end else begin
            k = {1'b1, ~m_brk, m_ext, b};
            exp_q.push_back(k);
            m_last = k[9:0];
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    task automatic frame(logic [7:0] b, bit pflip = 0, bit stop = 1);
        send(b, pflip, stop, 11);
        model(b, !pflip && stop);
        cyc(20);
    endtask

    task automatic verify(string tag);
        check({tag, ":n"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, ":key"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        check({tag, ":err"}, err_seen, exp_err);
        check({tag, ":hold"}, bus.ps2_key, {1'b0, m_last});
    endtask

    initial begin
        int r;
        logic [7:0] b;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset = 1'b1;
        model_reset();
        cyc(4);
        check("rst_key", bus.ps2_key, 11'h000);
        check("rst_err", bus.frame_err, 1'b0);
        reset = 1'b0;
        cyc(5);

        frame(8'h1C);
        verify("make");
        check("make_val", m_last, 10'h21C);

        frame(8'hF0); frame(8'h1C);
        verify("break");

        frame(8'hE0); frame(8'h75);
        verify("ext_make");
        frame(8'hE0); frame(8'hF0); frame(8'h75);
        verify("ext_break");

        frame(8'h1C, 1, 1);
        verify("par_err");
        frame(8'h29);
        verify("after_par");

        frame(8'hE1); frame(8'h14); frame(8'h77); frame(8'hE1);
        frame(8'hF0); frame(8'h14); frame(8'hF0); frame(8'h77);
        verify("pause");
        frame(8'h1C);
        verify("after_pause");

        frame(8'h1C, 0, 0);
        verify("stop_err");

        frame(8'hE0);
        send(8'h5A, 0, 1, 5);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        model_reset();
        cyc(5);
        verify("mid_rst");
        frame(8'h1C);
        verify("after_rst");

        for (int i = 0; i < 6; i++) begin
            bus.ps2_clk = 1'b0;
            cyc(1 + int'($urandom % 2));
            bus.ps2_clk = 1'b1;
            cyc(5);
        end
        frame(8'h29);
        verify("glitch");

`ifdef PS2_TIMEOUT_EN
        send(8'h3C, 0, 1, 5);
        cyc(TMO + 10);
        exp_err++;
        m_brk = 0;
        m_ext = 0;
        verify("timeout");
        frame(8'h29);
        verify("after_tmo");
`endif

        for (int i = 0; i < 120; i++) begin
            r = int'($urandom % 16);
            if (r == 0)      b = 8'hF0;
            else if (r == 1) b = 8'hE0;
            else if (r == 2) b = 8'hE1;
            else if (r == 3) b = ign[$urandom % 7];
            else             b = 8'($urandom);
            frame(b, ($urandom % 10) == 0, ($urandom % 16) != 0);
            verify("rand");
        end

        check("dbl_strobe", dbl, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
